// File: rtl/bubble_sort_pkg.sv
// bubble_sort_pkg: FSM state type and derived-width helper shared by the bubble sorter.
package bubble_sort_pkg;
   typedef enum logic [1:0] {IDLE, CMP, SWAP, PASS_END} state_t;
   function automatic int cnt_w(input int addr_w);
      return 2 * addr_w;
   endfunction
endpackage

// File: rtl/bubble_sort_param_sort_cmp.sv
// sort_cmp: flags a neighbouring pair that is out of order; equal words never swap, keeping the sort stable.
module sort_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             descending_i,
   output logic             out_of_order_o
);
   assign out_of_order_o = descending_i ? (a_i < b_i) : (a_i > b_i);
endmodule

// File: rtl/bubble_sort_param.sv
// bubble_sort_param: in-place bubble sorter over a DEPTH x WIDTH register array with
// load/read ports, runtime direction, early exit on a swap-free pass and a swap counter.
module bubble_sort_param
   import bubble_sort_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CNT_W  = cnt_w(ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              descending_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  swap_count_o
);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d, bound_q, bound_d, i_nx;
   logic              swapped_q, swapped_d, desc_q, desc_d, done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  a, b;
   logic              ooo, last, do_swap;

   assign i_nx = i_q + ADDR_W'(1);
   assign a    = mem_q[i_q];
   assign b    = mem_q[i_nx];
   assign last = (i_q == bound_q - ADDR_W'(1));

   sort_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a_i           (a),
      .b_i           (b),
      .descending_i  (desc_q),
      .out_of_order_o(ooo)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      bound_d   = bound_q;
      swapped_d = swapped_q;
      cnt_d     = cnt_q;
      desc_d    = desc_q;
      done_d    = done_q;
      do_swap   = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            desc_d    = descending_i;
            i_d       = '0;
            bound_d   = LAST;
            swapped_d = 1'b0;
            cnt_d     = '0;
            done_d    = 1'b0;
            state_d   = CMP;
         end
         CMP: begin
            state_d = ooo ? SWAP : last ? PASS_END : CMP;
            i_d     = (ooo || last) ? i_q : i_nx;
         end
         SWAP: begin
            do_swap   = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            swapped_d = 1'b1;
            state_d   = last ? PASS_END : CMP;
            i_d       = last ? i_q : i_nx;
         end
         PASS_END: if (!swapped_q || bound_q == ADDR_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            bound_d   = bound_q - ADDR_W'(1);
            i_d       = '0;
            swapped_d = 1'b0;
            state_d   = CMP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         i_q       <= '0;
         bound_q   <= LAST;
         swapped_q <= 1'b0;
         desc_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         bound_q   <= bound_d;
         swapped_q <= swapped_d;
         desc_q    <= desc_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end

   // Array is deliberately unreset so an aborted sort leaves a permutation of the load.
   always_ff @(posedge clk)
      if (do_swap) begin
         mem_q[i_q]  <= b;
         mem_q[i_nx] <= a;
      end else if (wr_en_i && state_q == IDLE && {1'b0, wr_addr_i} < DEPTH_W)
         mem_q[wr_addr_i] <= wr_data_i;

   assign rd_data_o    = ({1'b0, rd_addr_i} < DEPTH_W) ? mem_q[rd_addr_i] : '0;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign swap_count_o = cnt_q;
endmodule

// File: tb/tb_bubble_sort_param.sv
// tb_bubble_sort_param: four sorter instances (8x4, 8x32, 8x8, 16x5) checked against a
// stable selection-sort model with inversion counting.
module tb_bubble_sort_param;
   logic        clk = 0, rst_n = 1, descending = 0;
   logic [3:0]  start = 0, wr_en = 0, busy, done;
   logic [4:0]  wr_addr = 0, rd_addr = 0;
   logic [15:0] wr_data = 0;
   logic [7:0]  rd4, rd32, rd8;
   logic [15:0] rd5;
   logic [3:0]  sc4;
   logic [9:0]  sc32;
   logic [5:0]  sc8, sc5;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   bubble_sort_param #(.WIDTH(8), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start_i(start[0]), .descending_i(descending),
      .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[1:0]), .wr_data_i(wr_data[7:0]),
      .rd_addr_i(rd_addr[1:0]), .rd_data_o(rd4), .busy_o(busy[0]), .done_o(done[0]),
      .swap_count_o(sc4));
   bubble_sort_param #(.WIDTH(8), .DEPTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .start_i(start[1]), .descending_i(descending),
      .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr), .wr_data_i(wr_data[7:0]),
      .rd_addr_i(rd_addr), .rd_data_o(rd32), .busy_o(busy[1]), .done_o(done[1]),
      .swap_count_o(sc32));
   bubble_sort_param #(.WIDTH(8), .DEPTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start_i(start[2]), .descending_i(descending),
      .wr_en_i(wr_en[2]), .wr_addr_i(wr_addr[2:0]), .wr_data_i(wr_data[7:0]),
      .rd_addr_i(rd_addr[2:0]), .rd_data_o(rd8), .busy_o(busy[2]), .done_o(done[2]),
      .swap_count_o(sc8));
   bubble_sort_param #(.WIDTH(16), .DEPTH(5)) u5 (
      .clk(clk), .rst_n(rst_n), .start_i(start[3]), .descending_i(descending),
      .wr_en_i(wr_en[3]), .wr_addr_i(wr_addr[2:0]), .wr_data_i(wr_data),
      .rd_addr_i(rd_addr[2:0]), .rd_data_o(rd5), .busy_o(busy[3]), .done_o(done[3]),
      .swap_count_o(sc5));

   function automatic logic [15:0] rd_k(input int k);
      return k == 0 ? {8'h0, rd4} : k == 1 ? {8'h0, rd32} : k == 2 ? {8'h0, rd8} : rd5;
   endfunction

   function automatic logic [31:0] sc_k(input int k);
      return k == 0 ? {28'h0, sc4} : k == 1 ? {22'h0, sc32} : k == 2 ? {26'h0, sc8} : {26'h0, sc5};
   endfunction

   // Expected result: repeatedly take the first extreme element (stable); swaps = strict inversions.
   function automatic void model(input logic [15:0] a [32], input int n, input bit desc,
                                 output logic [15:0] e [32], output int inv);
      logic [15:0] q [$];
      int p;
      inv = 0;
      for (int x = 0; x < 32; x++) e[x] = 0;
      for (int x = 0; x < n; x++) begin
         q.push_back(a[x]);
         for (int y = x + 1; y < n; y++) if (desc ? a[x] < a[y] : a[x] > a[y]) inv++;
      end
      for (int x = 0; x < n; x++) begin
         p = 0;
         for (int y = 1; y < q.size(); y++) if (desc ? q[y] > q[p] : q[y] < q[p]) p = y;
         e[x] = q[p];
         q.delete(p);
      end
   endfunction

   task automatic load(input int k, input logic [15:0] a [32], input int n);
      for (int x = 0; x < n; x++) begin
         @(negedge clk);
         wr_en[k] = 1; wr_addr = 5'(x); wr_data = a[x];
      end
      @(negedge clk);
      wr_en[k] = 0;
   endtask

   task automatic launch(input int k, input bit desc);
      @(negedge clk);
      descending = desc; start[k] = 1;
      @(posedge clk); #1;
      start[k] = 0;
   endtask

   task automatic wait_done(input int k, output int cyc);
      cyc = 0;
      while (!done[k] && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic readback(input int k, input int n, output logic [15:0] r [32]);
      for (int x = 0; x < 32; x++) r[x] = 0;
      for (int x = 0; x < n; x++) begin
         rd_addr = 5'(x); #1;
         r[x] = rd_k(k);
      end
   endtask

   task automatic test_reset;
      #2 rst_n = 0; #2;
      for (int k = 0; k < 4; k++) begin
         checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b exp 0", k, busy[k]); end
         checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b exp 0", k, done[k]); end
         checks++; if (sc_k(k) !== 32'd0) begin errors++; $display("FAIL reset_swaps[%0d]: got %0h exp 0", k, sc_k(k)); end
      end
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_reverse4;
      logic [15:0] a [32], e [32], r [32];
      int inv, cyc;
      for (int x = 0; x < 32; x++) a[x] = 0;
      for (int x = 0; x < 4; x++) a[x] = 16'(4 - x);
      model(a, 4, 0, e, inv);
      load(0, a, 4);
      launch(0, 0);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rev4_busy: got %b exp 1", busy[0]); end
      wait_done(0, cyc);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL rev4_done: got %b exp 1", done[0]); end
      checks++; if (cyc !== 15) begin errors++; $display("FAIL rev4_cycles: got %0d exp 15", cyc); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rev4_busy_end: got %b exp 0", busy[0]); end
      checks++; if (sc_k(0) !== 32'd6) begin errors++; $display("FAIL rev4_swaps: got %0d exp 6", sc_k(0)); end
      readback(0, 4, r);
      for (int x = 0; x < 4; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL rev4_data[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
   endtask

   task automatic test_sorted32;
      logic [15:0] a [32], r [32];
      int cyc;
      for (int x = 0; x < 32; x++) a[x] = 16'(x);
      load(1, a, 32);
      launch(1, 0);
      wait_done(1, cyc);
      checks++; if (cyc !== 32) begin errors++; $display("FAIL sorted32_cycles: got %0d exp 32", cyc); end
      checks++; if (sc_k(1) !== 32'd0) begin errors++; $display("FAIL sorted32_swaps: got %0d exp 0", sc_k(1)); end
      readback(1, 32, r);
      for (int x = 0; x < 32; x++) begin
         checks++; if (r[x] !== a[x]) begin errors++; $display("FAIL sorted32_data[%0d]: got %0h exp %0h", x, r[x], a[x]); end
      end
   endtask

   task automatic test_desc8;
      int v [8] = '{5, 9, 5, 0, 255, 1, 9, 3};
      logic [15:0] a [32], e [32], r [32];
      int inv, cyc;
      for (int x = 0; x < 32; x++) a[x] = 0;
      for (int x = 0; x < 8; x++) a[x] = 16'(v[x]);
      model(a, 8, 1, e, inv);
      load(2, a, 8);
      launch(2, 1);
      wait_done(2, cyc);
      checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL desc8_done: got %b exp 1", done[2]); end
      checks++; if (sc_k(2) !== 32'(inv)) begin errors++; $display("FAIL desc8_swaps: got %0d exp %0d", sc_k(2), inv); end
      readback(2, 8, r);
      for (int x = 0; x < 8; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL desc8_data[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
   endtask

   task automatic test_mid_sort;
      logic [15:0] a [32], e [32], r [32];
      logic [31:0] prev;
      int inv, cyc;
      for (int x = 0; x < 32; x++) a[x] = 0;
      for (int x = 0; x < 8; x++) a[x] = 16'($urandom_range(0, 160));
      a[0] = 16'd255;
      model(a, 8, 0, e, inv);
      load(2, a, 8);
      launch(2, 0);
      cyc = 0;
      while (sc_k(2) == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
      prev = sc_k(2);
      checks++; if (prev === 32'd0) begin errors++; $display("FAIL mid_first_swap: got %0d exp nonzero", prev); end
      @(negedge clk);
      wr_en[2] = 1; wr_addr = 0; wr_data = 16'h00AA; start[2] = 1; descending = 1;
      @(posedge clk); #1;
      wr_en[2] = 0; start[2] = 0; descending = 0;
      checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b exp 1", busy[2]); end
      checks++; if (!(sc_k(2) >= prev)) begin errors++; $display("FAIL mid_swaps_kept: got %0d exp >= %0d", sc_k(2), prev); end
      wait_done(2, cyc);
      checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL mid_done: got %b exp 1", done[2]); end
      checks++; if (sc_k(2) !== 32'(inv)) begin errors++; $display("FAIL mid_swaps: got %0d exp %0d", sc_k(2), inv); end
      readback(2, 8, r);
      for (int x = 0; x < 8; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL mid_data[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] a [32], e [32], r [32], rs [32];
      int inv, cyc;
      for (int x = 0; x < 32; x++) a[x] = 16'($urandom_range(0, 255));
      load(1, a, 32);
      launch(1, 1'($urandom_range(0, 1)));
      repeat (60) @(posedge clk);
      #1;
      checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b exp 1", busy[1]); end
      #2 rst_n = 0; #1;
      checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy[1]); end
      checks++; if (done[1] !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b exp 0", done[1]); end
      checks++; if (sc_k(1) !== 32'd0) begin errors++; $display("FAIL rstmid_swaps: got %0d exp 0", sc_k(1)); end
      readback(1, 32, r);
      model(a, 32, 0, e, inv);
      model(r, 32, 0, rs, cyc);
      for (int x = 0; x < 32; x++) begin
         checks++; if (rs[x] !== e[x]) begin errors++; $display("FAIL rstmid_perm[%0d]: got %0h exp %0h", x, rs[x], e[x]); end
      end
      @(negedge clk) rst_n = 1;
      launch(1, 0);
      wait_done(1, cyc);
      checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL rstmid_redo_done: got %b exp 1", done[1]); end
      readback(1, 32, r);
      for (int x = 0; x < 32; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL rstmid_redo[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
   endtask

   task automatic test_nonpow2;
      logic [15:0] a [32], e [32], r [32];
      int inv, cyc;
      bit desc;
      desc = 1'($urandom_range(0, 1));
      for (int x = 0; x < 32; x++) a[x] = 0;
      for (int x = 0; x < 5; x++) a[x] = 16'($urandom);
      load(3, a, 5);
      rd_addr = 5'd7; #1;
      checks++; if (rd5 !== 16'h0) begin errors++; $display("FAIL np2_rd7: got %0h exp 0", rd5); end
      @(negedge clk);
      wr_en[3] = 1; wr_addr = 5'd6; wr_data = 16'hBEEF;
      @(negedge clk);
      wr_en[3] = 0;
      rd_addr = 5'd6; #1;
      checks++; if (rd5 !== 16'h0) begin errors++; $display("FAIL np2_rd6: got %0h exp 0", rd5); end
      readback(3, 5, r);
      for (int x = 0; x < 5; x++) begin
         checks++; if (r[x] !== a[x]) begin errors++; $display("FAIL np2_keep[%0d]: got %0h exp %0h", x, r[x], a[x]); end
      end
      model(a, 5, desc, e, inv);
      launch(3, desc);
      wait_done(3, cyc);
      checks++; if (done[3] !== 1'b1) begin errors++; $display("FAIL np2_done: got %b exp 1", done[3]); end
      checks++; if (sc_k(3) !== 32'(inv)) begin errors++; $display("FAIL np2_swaps: got %0d exp %0d", sc_k(3), inv); end
      readback(3, 5, r);
      for (int x = 0; x < 5; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL np2_data[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] a [32], e [32], r [32];
      int inv, cyc;
      for (int x = 0; x < 32; x++) a[x] = 0;
      a[0] = 16'd9; a[1] = 16'd2; a[2] = 16'd3; a[3] = 16'd4;
      model(a, 4, 0, e, inv);
      @(negedge clk);
      wr_en[0] = 1; wr_addr = 0; wr_data = 16'd9; start[0] = 1; descending = 0;
      @(posedge clk); #1;
      wr_en[0] = 0; start[0] = 0;
      wait_done(0, cyc);
      checks++; if (sc_k(0) !== 32'(inv)) begin errors++; $display("FAIL b2b_wr_swaps: got %0d exp %0d", sc_k(0), inv); end
      readback(0, 4, r);
      for (int x = 0; x < 4; x++) begin
         checks++; if (r[x] !== e[x]) begin errors++; $display("FAIL b2b_wr_data[%0d]: got %0h exp %0h", x, r[x], e[x]); end
      end
      model(e, 4, 1, a, inv);
      @(negedge clk);
      descending = 1; start[0] = 1;
      @(posedge clk); #1;
      wait_done(0, cyc);
      checks++; if (sc_k(0) !== 32'(inv)) begin errors++; $display("FAIL b2b_first_swaps: got %0d exp %0d", sc_k(0), inv); end
      @(posedge clk); #1;
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL b2b_done_fall: got %b exp 0", done[0]); end
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b exp 1", busy[0]); end
      start[0] = 0;
      wait_done(0, cyc);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b exp 1", done[0]); end
      checks++; if (sc_k(0) !== 32'd0) begin errors++; $display("FAIL b2b_second_swaps: got %0d exp 0", sc_k(0)); end
      readback(0, 4, r);
      for (int x = 0; x < 4; x++) begin
         checks++; if (r[x] !== a[x]) begin errors++; $display("FAIL b2b_data[%0d]: got %0h exp %0h", x, r[x], a[x]); end
      end
   endtask

   initial begin
      test_reset;
      test_reverse4;
      test_sorted32;
      test_desc8;
      test_mid_sort;
      test_reset_mid;
      test_nonpow2;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
